// File: rtl/controlador_bcd_compartilhado.sv
// controlador_bcd_compartilhado: N_REQ requesters share one combinational
// binary-to-BCD converter (BinarioParaBCD). The winner's operand is latched
// into op_reg at grant. After LAT settle cycles, the three BCD digits are
// registered and a one-cycle done pulse is issued.
// Optional macro BCD_ARB_PRIORIDADE_FIXA_EN: fixed priority (lowest index
// wins) instead of the default round-robin arbiter.

// Unrolled double-dabble: 8-bit binary to three BCD digits
module BinarioParaBCD (
  input  logic [7:0] bin_in,
  output logic [3:0] centenas,
  output logic [3:0] dezenas,
  output logic [3:0] unidades
);

  logic [19:0] sh;

  // Shift-add-3 over the 8 input bits
  always_comb begin
    sh = {12'b0, bin_in};
    for (int unsigned i = 0; i < 8; i++) begin
      if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = sh << 1;
    end
    unidades = sh[11:8];
    dezenas  = sh[15:12];
    centenas = sh[19:16];
  end

endmodule

module controlador_bcd_compartilhado #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LAT   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] bin_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [2:0]         src_id,
  output logic               busy,
  output logic               done,
  output logic [3:0]         bcd_centenas,
  output logic [3:0]         bcd_dezenas,
  output logic [3:0]         bcd_unidades
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [2:0]       src_q, src_d;
  logic [7:0]       op_q, op_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [3:0]       cen_q, cen_d;
  logic [3:0]       dez_q, dez_d;
  logic [3:0]       uni_q, uni_d;

  logic [3:0]       conv_cen, conv_dez, conv_uni;

  // Padded views so the arbiter can index with exact 3-/6-bit selectors
  logic [7:0]       req_pad;
  logic [63:0]      bin_pad;
  logic [2:0]       win;
  logic [7:0]       win_onehot;

  assign req_pad    = 8'(req);
  assign bin_pad    = 64'(bin_in);
  assign win_onehot = 8'd1 << win;

  BinarioParaBCD u_bcd (
    .bin_in   (op_q),
    .centenas (conv_cen),
    .dezenas  (conv_dez),
    .unidades (conv_uni)
  );

`ifdef BCD_ARB_PRIORIDADE_FIXA_EN
  // Fixed priority: lowest asserted request index wins
  always_comb begin
    logic found;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && req_pad[3'(k)]) begin
        win   = 3'(k);
        found = 1'b1;
      end
    end
  end
`else
  logic [2:0] ptr_q, ptr_d;
  logic [3:0] ptr_nxt;

  // Round-robin: first asserted request searching upward from ptr, wrapping
  always_comb begin
    logic       found;
    logic [3:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
      if (!found && req_pad[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end
    end
  end

  // Pointer moves to the index after the winner, modulo N_REQ
  always_comb begin
    ptr_nxt = {1'b0, win} + 4'd1;
    if (ptr_nxt >= 4'(N_REQ)) ptr_nxt = '0;
    ptr_d = ptr_q;
    if (state_q == IDLE && (|req)) ptr_d = ptr_nxt[2:0];
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  // Next-state and datapath control for grant / settle / capture
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    src_d   = src_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    cen_d   = cen_q;
    dez_d   = dez_q;
    uni_d   = uni_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = win_onehot[N_REQ-1:0];
          src_d   = win;
          op_d    = bin_pad[{win, 3'b000} +: 8];
          cnt_d   = 4'(LAT);
          state_d = CONV;
        end
      end
      CONV: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cen_d   = conv_cen;
          dez_d   = conv_dez;
          uni_d   = conv_uni;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      src_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      cen_q   <= '0;
      dez_q   <= '0;
      uni_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      src_q   <= src_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      cen_q   <= cen_d;
      dez_q   <= dez_d;
      uni_q   <= uni_d;
    end
  end

  assign gnt          = gnt_q;
  assign src_id       = src_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign bcd_centenas = cen_q;
  assign bcd_dezenas  = dez_q;
  assign bcd_unidades = uni_q;

endmodule

// File: tb/tb_controlador_bcd_compartilhado.sv
// Directed bench for controlador_bcd_compartilhado (N_REQ=4, LAT=1).
// Honours BCD_ARB_PRIORIDADE_FIXA_EN for the arbitration-order expectations.
module tb_controlador_bcd_compartilhado;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned LAT   = 1;

  logic               clk;
  logic               rst_n;
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] bin_in;
  logic [N_REQ-1:0]   gnt;
  logic [2:0]         src_id;
  logic               busy;
  logic               done;
  logic [3:0]         bcd_centenas;
  logic [3:0]         bcd_dezenas;
  logic [3:0]         bcd_unidades;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc;

  controlador_bcd_compartilhado #(.N_REQ(N_REQ), .LAT(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .bin_in       (bin_in),
    .gnt          (gnt),
    .src_id       (src_id),
    .busy         (busy),
    .done         (done),
    .bcd_centenas (bcd_centenas),
    .bcd_dezenas  (bcd_dezenas),
    .bcd_unidades (bcd_unidades)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits at least one cycle, then until done is seen (bounded)
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (done !== 1'b1 && cycles < 20);
    chk("done_seen", 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] digits();
    return 32'({bcd_centenas, bcd_dezenas, bcd_unidades});
  endfunction

  // One conversion from IDLE on requester idx; called at a negedge
  task automatic do_conv(input int idx, input logic [7:0] val, input logic [11:0] exp_d);
    int c;
    bin_in[8*idx +: 8] = val;
    req = 4'(1 << idx);
    @(negedge clk);
    chk("grant", 32'(gnt), 32'(1 << idx));
    chk("busy_on", 32'(busy), 32'd1);
    req = '0;
    wait_done(c);
    chk("latency", 32'(c), 32'(LAT + 1));
    chk("digits", digits(), 32'(exp_d));
    chk("src_id", 32'(src_id), 32'(idx));
    chk("gnt_at_done", 32'(gnt), 32'(1 << idx));
    @(negedge clk);
    chk("done_drop", 32'(done), 32'd0);
    chk("gnt_drop", 32'(gnt), 32'd0);
    chk("busy_off", 32'(busy), 32'd0);
  endtask

  int exp_rr [5];
  int exp_pair [3];

  initial begin
`ifdef BCD_ARB_PRIORIDADE_FIXA_EN
    exp_rr   = '{0, 0, 0, 0, 0};
    exp_pair = '{1, 1, 1};
`else
    exp_rr   = '{0, 1, 2, 3, 0};
    exp_pair = '{1, 3, 1};
`endif
    rst_n  = 1'b0;
    req    = '0;
    bin_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_src", 32'(src_id), 32'd0);
    chk("rst_digits", digits(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Max operand on requester 0, then boundary operands on requester 2
    do_conv(0, 8'd255, 12'h255);
    do_conv(2, 8'd0,   12'h000);
    do_conv(2, 8'd99,  12'h099);
    do_conv(2, 8'd100, 12'h100);
    do_conv(2, 8'd128, 12'h128);

    // Operand changes after grant must not affect the result
    bin_in[15:8] = 8'd42;
    req = 4'b0010;
    @(negedge clk);
    chk("chg_grant", 32'(gnt), 32'h2);
    bin_in[15:8] = 8'd200;
    req = '0;
    wait_done(cyc);
    chk("chg_digits", digits(), 32'h042);
    chk("chg_src", 32'(src_id), 32'd1);
    @(negedge clk);

    // Reset during CONV aborts everything immediately
    bin_in[7:0] = 8'd77;
    req = 4'b0001;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_gnt", 32'(gnt), 32'd0);
    chk("abort_busy0", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_digits", digits(), 32'd0);
    chk("abort_src", 32'(src_id), 32'd0);
    bin_in = {8'd40, 8'd30, 8'd20, 8'd10};
    req = 4'hF;
    @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // All requesters held: arbitration order and throughput
    wait_done(cyc);
    chk("first_latency", 32'(cyc), 32'(LAT + 2));
    chk("first_src", 32'(src_id), 32'(exp_rr[0]));
    chk("first_digits", digits(), 32'h010);
    for (int g = 1; g < 5; g++) begin
      wait_done(cyc);
      chk("rr_spacing", 32'(cyc), 32'(LAT + 3));
      chk("rr_src", 32'(src_id), 32'(exp_rr[g]));
      chk("rr_gnt", 32'(gnt), 32'(1 << exp_rr[g]));
    end

    // Requesters 1 and 3 held
    req = 4'b1010;
    for (int g = 0; g < 3; g++) begin
      wait_done(cyc);
      chk("pair_src", 32'(src_id), 32'(exp_pair[g]));
      chk("pair_digits", digits(), (exp_pair[g] == 1) ? 32'h020 : 32'h040);
    end
    req = '0;
    repeat (3) @(negedge clk);
    chk("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/controlador_bcd_compartilhado.md
# controlador_bcd_compartilhado

Sequential controller that shares one combinational `BinarioParaBCD` converter among `N_REQ` requesters (score counters, timers, menu values) feeding the 7-segment display path. It arbitrates requests and latches the winner's 8-bit operand into the converter input register. It waits a programmable settle time for the unrolled double-dabble chain, then captures the three BCD digits into output registers with a one-cycle `done` pulse.

## Interface

- `N_REQ`, 4, number of requesters (2..8).
- `LAT`, 1, settle cycles allowed for the converter after the operand register loads (0..15).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N_REQ: per-requester conversion request, level; bit i = requester i.
- `bin_in` in 8*N_REQ: packed operands; requester i on bits [8*i+7:8*i].
- `gnt` out N_REQ: one-hot grant, high for the whole operation of the winner.
- `src_id` out 3: index of the current/last granted requester.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when result registers are valid for `src_id`.
- `bcd_centenas` out 4: registered hundreds digit.
- `bcd_dezenas` out 4: registered tens digit.
- `bcd_unidades` out 4: registered units digit.

## Operation

- Instantiates exactly one `BinarioParaBCD`. Its `bin_in` is driven only from internal 8-bit `op_reg`.
- States:
  - IDLE: `busy`=0.
    - If any `req` bit is set, pick a winner, load `op_reg` from the winner's `bin_in` slice, set `gnt`/`src_id`, load `cnt`=LAT, go to CONV.
    - Otherwise stay in IDLE.
  - CONV:
    - If `cnt`≠0, decrement `cnt` and stay.
    - If `cnt`=0, capture the converter outputs into the three digit registers, assert `done`, go to DONE.
  - DONE: deassert `done`, clear `gnt`, go to IDLE.
- Round-robin arbitration:
  - Pointer `ptr` (reset 0) marks the first index searched, ascending modulo N_REQ.
  - After each grant, `ptr` = winner+1 mod N_REQ.
- The operand is sampled only at grant. Changes to `bin_in` or a dropped `req` during CONV/DONE do not affect the result; the operation always completes and `done` still pulses.
- A requester holding `req` high through DONE is re-eligible in the next IDLE. Round-robin still serves other pending requesters first.
- Digit registers hold their value until the next capture. `src_id` holds the last winner while idle.
- Results are exact for 0..255: centenas 0..2, dezenas/unidades 0..9.

## Timing

- Reset values (asynchronous, immediate on `rst_n`=0):
  - state IDLE;
  - `gnt`=0, `src_id`=0, `busy`=0, `done`=0;
  - all digits 0, `op_reg`=0, `cnt`=0, `ptr`=0.
- Reset mid-operation aborts the conversion. No `done` is emitted and the request is lost; requesters re-request after reset.
- Edge E0, IDLE with `req`≠0: `gnt`, `busy`, `src_id` and `op_reg` become valid after E0.
- `done` and the digits become valid after edge E(LAT+1) and stay for one cycle. With LAT=0, they are valid after E1.
- IDLE is re-entered after E(LAT+2). The earliest next grant is at E(LAT+3). Throughput is one conversion per LAT+3 cycles.
- `gnt` is high from after E0 through after E(LAT+2). It drops on the same edge on which `done` drops.
- Simultaneous requests in the same cycle are resolved by the arbiter; only one grant is issued per operation.

## Configuration

- `BCD_ARB_PRIORIDADE_FIXA_EN`:
  - Defined: fixed priority; the lowest asserted `req` index always wins, and `ptr` is not implemented.
  - Undefined (default): round-robin as described in Operation.

## Test plan

- Single requester 0, `bin_in`=255, LAT=1, req at E0 -> `done` after E2 with digits 2/5/5, `gnt`=0001 until after E3, `busy` back to 0.
- Operands 0, 99, 100, 128 on requester 2 -> digits 0/0/0, 0/9/9, 1/0/0, 1/2/8; `src_id`=2 on each `done`.
- All four `req` held high from reset, round-robin -> grant order 0,1,2,3,0; each `done` spaced LAT+3 cycles apart.
- With `BCD_ARB_PRIORIDADE_FIXA_EN`, `req`=1010 held -> requester 1 is granted repeatedly; requester 3 is never granted.
- Change `bin_in` from 42 to 200 one cycle after grant -> result digits 0/4/2.
- `rst_n` low during CONV -> `done` never pulses, all outputs 0 immediately; after release with `req` high, a fresh grant to requester 0.
